// File: rtl/hash_table_access_uram.sv
`timescale 1ns/1ps
// hash_table_access_uram
//   Executes hashed search/insert/delete/nop requests against a direct-mapped
//   table of {valid,key,value} entries held in a single-port-write, sync-read
//   memory. Fixed 3-cycle latency, one request per cycle, no stalls. Requests
//   to the same index in consecutive cycles see each other through bypass.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   en_in/opt_in          request valid / opcode (00 search, 01 insert, 10 delete, 11 nop)
//   index_in              table address
//   key_in/value_in       request key / insert data
//   ready                 0 while the table is being cleared after reset
//   en_out/opt_out        result valid / opcode of the retired request
//   key_out/value_out     key of the retired request / search data or value_in
//   status                00 miss, 01 hit, 10 collision
module hash_table_access_uram #(
  parameter int KEY_WIDTH   = 32,
  parameter int INDEX_WIDTH = 12,
  parameter int VALUE_WIDTH = 31
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en_in,
  input  logic [1:0]             opt_in,
  input  logic [INDEX_WIDTH-1:0] index_in,
  input  logic [KEY_WIDTH-1:0]   key_in,
  input  logic [VALUE_WIDTH-1:0] value_in,
  output logic                   ready,
  output logic                   en_out,
  output logic [1:0]             opt_out,
  output logic [KEY_WIDTH-1:0]   key_out,
  output logic [VALUE_WIDTH-1:0] value_out,
  output logic [1:0]             status
);

  localparam int ENTRY_W = 1 + KEY_WIDTH + VALUE_WIDTH;
  localparam int DEPTH   = 2**INDEX_WIDTH;

  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;

  localparam logic [1:0] ST_MISS = 2'b00;
  localparam logic [1:0] ST_HIT  = 2'b01;
  localparam logic [1:0] ST_COLL = 2'b10;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] init_cnt;

  // Entry layout: {valid, key, value}
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic                   mem_we;
  logic [INDEX_WIDTH-1:0] mem_waddr;
  logic [ENTRY_W-1:0]     mem_wdata;

  logic                   acc;

  logic                   vld_p0;
  logic [1:0]             opt_p0;
  logic [INDEX_WIDTH-1:0] idx_p0;
  logic [KEY_WIDTH-1:0]   key_p0;
  logic [VALUE_WIDTH-1:0] val_p0;

  logic                   vld_p1;
  logic [1:0]             opt_p1;
  logic [INDEX_WIDTH-1:0] idx_p1;
  logic [KEY_WIDTH-1:0]   key_p1;
  logic [VALUE_WIDTH-1:0] val_p1;
  logic [ENTRY_W-1:0]     rdata_p1;
  logic [ENTRY_W-1:0]     ent_byp_p1;

  logic                   vld_p2;
  logic [1:0]             opt_p2;
  logic [INDEX_WIDTH-1:0] idx_p2;
  logic [KEY_WIDTH-1:0]   key_p2;
  logic [VALUE_WIDTH-1:0] val_p2;
  logic [ENTRY_W-1:0]     ent_p2;

  logic                   ent_vld_p2;
  logic [KEY_WIDTH-1:0]   ent_key_p2;
  logic [VALUE_WIDTH-1:0] ent_val_p2;
  logic                   match_p2;
  logic                   wr_en_p2;
  logic [ENTRY_W-1:0]     wr_data_p2;
  logic [1:0]             st_p2;
  logic [VALUE_WIDTH-1:0] res_val_p2;

  // Registered copy of last cycle's write: covers a read that was issued on
  // the same edge as that write (memory is read-before-write).
  logic                   wq_vld;
  logic [INDEX_WIDTH-1:0] wq_idx;
  logic [ENTRY_W-1:0]     wq_data;

  // Table clear sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
    end else if (state == S_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == {INDEX_WIDTH{1'b1}}) begin
        state <= S_RUN;
        ready <= 1'b1;
      end
    end
  end

  assign acc = en_in & ready;

  // Single write port: clearing owns it during INIT, stage 3 afterwards
  always_comb begin
    mem_we    = wr_en_p2;
    mem_waddr = idx_p2;
    mem_wdata = wr_data_p2;
    if (state == S_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rdata_p1 <= mem[idx_p0];
  end

  // ---- stage 1: request capture, read address ----
  always_ff @(posedge clk) begin
    opt_p0 <= opt_in;
    idx_p0 <= index_in;
    key_p0 <= key_in;
    val_p0 <= value_in;
  end

  // ---- stage 2: memory data returns, bypass of in-flight writes ----
  always_ff @(posedge clk) begin
    opt_p1 <= opt_p0;
    idx_p1 <= idx_p0;
    key_p1 <= key_p0;
    val_p1 <= val_p0;
  end

  // Stage-3 write is younger than the registered copy, so it is applied last
  always_comb begin
    ent_byp_p1 = rdata_p1;
    if (wq_vld && (wq_idx == idx_p1)) ent_byp_p1 = wq_data;
    if (wr_en_p2 && (idx_p2 == idx_p1)) ent_byp_p1 = wr_data_p2;
  end

  // ---- stage 3: compare, write back, register results ----
  always_ff @(posedge clk) begin
    opt_p2  <= opt_p1;
    idx_p2  <= idx_p1;
    key_p2  <= key_p1;
    val_p2  <= val_p1;
    ent_p2  <= ent_byp_p1;
    wq_idx  <= idx_p2;
    wq_data <= wr_data_p2;
  end

  assign ent_vld_p2 = ent_p2[ENTRY_W-1];
  assign ent_key_p2 = ent_p2[VALUE_WIDTH +: KEY_WIDTH];
  assign ent_val_p2 = ent_p2[0 +: VALUE_WIDTH];
  assign match_p2   = ent_vld_p2 && (ent_key_p2 == key_p2);

  always_comb begin
    wr_en_p2   = 1'b0;
    wr_data_p2 = {1'b1, key_p2, val_p2};
    st_p2      = ST_MISS;
    res_val_p2 = val_p2;
    case (opt_p2)
      OP_SEARCH: begin
        st_p2      = match_p2 ? ST_HIT : ST_MISS;
        res_val_p2 = match_p2 ? ent_val_p2 : '0;
      end
      OP_INSERT: begin
        if (match_p2) begin
          wr_en_p2 = 1'b1;
          st_p2    = ST_HIT;
        end else if (!ent_vld_p2) begin
          wr_en_p2 = 1'b1;
        end else begin
          st_p2 = ST_COLL;
        end
      end
      OP_DELETE: begin
        if (match_p2) begin
          wr_en_p2   = 1'b1;
          wr_data_p2 = {1'b0, ent_key_p2, ent_val_p2};
          st_p2      = ST_HIT;
        end
      end
      default: ;
    endcase
    if (!vld_p2) wr_en_p2 = 1'b0;
  end

  // Control: valids, write-copy valid and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      wq_vld    <= 1'b0;
      en_out    <= 1'b0;
      opt_out   <= '0;
      key_out   <= '0;
      value_out <= '0;
      status    <= '0;
    end else begin
      vld_p0 <= acc;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      wq_vld <= wr_en_p2;
      en_out <= vld_p2;
      if (vld_p2) begin
        opt_out   <= opt_p2;
        key_out   <= key_p2;
        value_out <= res_val_p2;
        status    <= st_p2;
      end
    end
  end

endmodule
